// File: rtl/sample_voter_pkg.sv
// Shared types and constants for the sample_voter slice.
// FSM state encoding and divider counter width.
package sample_voter_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S0   = 2'd1,
        S1   = 2'd2,
        S2   = 2'd3
    } state_t;

    // Non-unanimous triple: at least one sample disagrees.
    function automatic logic split3(
        input logic a,
        input logic b,
        input logic c
    );
        return !((a == b) && (b == c));
    endfunction

endpackage

// File: rtl/majority_vote3.sv
// Combinational 2-of-3 majority.
// y is 1 when at least two of a, b, c are 1.
module majority_vote3 (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);

    assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/sample_voter.sv
// Oversampling 3-sample majority voter with valid/ready output buffer.
// Optional out_err (non-unanimous flag) when SAMPLE_VOTER_ERR_EN is defined.
module sample_voter
    import sample_voter_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic in,
    output logic out_val,
    input  logic out_rdy,
    output logic out_bit,
    output logic overrun
`ifdef SAMPLE_VOTER_ERR_EN
    ,
    output logic out_err
`endif
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] count;
    logic             s0;
    logic             s1;
    logic             samp;
    logic             fire;
    logic             load;
    logic             drop;
    logic             vote;

    // Sample strobe: divider at its last count in an active sampling state.
    assign samp = en && (state != IDLE) && (count == LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: advance one slot per sample, abort to IDLE when en drops.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (en) state_nx = S0;
            S0: begin
                if (!en)       state_nx = IDLE;
                else if (samp) state_nx = S1;
            end
            S1: begin
                if (!en)       state_nx = IDLE;
                else if (samp) state_nx = S2;
            end
            S2: begin
                if (!en)       state_nx = IDLE;
                else if (samp) state_nx = S0;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output decode: window close, buffer load or drop.
    always_comb begin
        fire = 1'b0;
        load = 1'b0;
        drop = 1'b0;
        if (samp && (state == S2)) begin
            fire = 1'b1;
        end
        if (fire) begin
            load = !out_val || out_rdy;
            drop = out_val && !out_rdy;
        end
    end

    // Divider and partial samples; cleared whenever sampling is not live.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            s0    <= 1'b0;
            s1    <= 1'b0;
        end else if ((state == IDLE) || !en) begin
            count <= '0;
            s0    <= 1'b0;
            s1    <= 1'b0;
        end else begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
            if (samp && (state == S0)) s0 <= in;
            if (samp && (state == S1)) s1 <= in;
        end
    end

    majority_vote3 u_vote (
        .a (s0),
        .b (s1),
        .c (in),
        .y (vote)
    );

    // One-entry output buffer; a vote arriving on a full, stalled buffer is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_val <= 1'b0;
            out_bit <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= drop;
            if (load) begin
                out_val <= 1'b1;
                out_bit <= vote;
            end else if (out_val && out_rdy) begin
                out_val <= 1'b0;
            end
        end
    end

`ifdef SAMPLE_VOTER_ERR_EN
    // Disagreement flag travels with out_bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_err <= 1'b0;
        end else if (load) begin
            out_err <= split3(s0, s1, in);
        end
    end
`endif

endmodule

// File: tb/tb_sample_voter.sv
// Directed self-checking bench for sample_voter (DIV=4).
// Covers windows, votes, overrun, back-to-back, abort and async reset.
module tb_sample_voter;

    logic clk;
    logic rst_n;
    logic en;
    logic in;
    logic out_val;
    logic out_rdy;
    logic out_bit;
    logic overrun;
`ifdef SAMPLE_VOTER_ERR_EN
    logic out_err;
`endif

    int checks = 0;
    int errors = 0;

    sample_voter #(.DIV(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .in      (in),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out_bit (out_bit),
        .overrun (overrun)
`ifdef SAMPLE_VOTER_ERR_EN
        ,
        .out_err (out_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; in = 1'b0; out_rdy = 1'b0;
        #3;
        checks++;
        if (out_val !== 1'b0) begin
            errors++; $display("FAIL reset_out_val: got %b want 0", out_val);
        end
        checks++;
        if (out_bit !== 1'b0) begin
            errors++; $display("FAIL reset_out_bit: got %b want 0", out_bit);
        end
        checks++;
        if (overrun !== 1'b0) begin
            errors++; $display("FAIL reset_overrun: got %b want 0", overrun);
        end
`ifdef SAMPLE_VOTER_ERR_EN
        checks++;
        if (out_err !== 1'b0) begin
            errors++; $display("FAIL reset_out_err: got %b want 0", out_err);
        end
`endif
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (out_val !== 1'b0) begin
            errors++; $display("FAIL idle_out_val: got %b want 0", out_val);
        end
    endtask

    // in held 1, ready high: valid pulses at 12, 24, 36.
    task automatic test_stream_ones();
        logic ev;
        in = 1'b1; out_rdy = 1'b1; en = 1'b1;
        tick();
        for (int c = 1; c <= 36; c++) begin
            tick();
            ev = ((c % 12) == 0);
            checks++;
            if (out_val !== ev) begin
                errors++;
                $display("FAIL stream_val c=%0d: got %b want %b", c, out_val, ev);
            end
            if (ev) begin
                checks++;
                if (out_bit !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_bit c=%0d: got %b want 1", c, out_bit);
                end
            end
            checks++;
            if (overrun !== 1'b0) begin
                errors++;
                $display("FAIL stream_ovr c=%0d: got %b want 0", c, overrun);
            end
        end
        en = 1'b0;
        tick();
        checks++;
        if (out_val !== 1'b0) begin
            errors++; $display("FAIL stream_drain: got %b want 0", out_val);
        end
    endtask

    task automatic test_votes();
        logic [2:0] pat [6];
        logic       exp_bit [6];
        logic       exp_err [6];
        pat[0] = 3'b101; exp_bit[0] = 1'b1; exp_err[0] = 1'b1;
        pat[1] = 3'b100; exp_bit[1] = 1'b0; exp_err[1] = 1'b1;
        pat[2] = 3'b000; exp_bit[2] = 1'b0; exp_err[2] = 1'b0;
        pat[3] = 3'b011; exp_bit[3] = 1'b1; exp_err[3] = 1'b1;
        pat[4] = 3'b110; exp_bit[4] = 1'b1; exp_err[4] = 1'b1;
        pat[5] = 3'b111; exp_bit[5] = 1'b1; exp_err[5] = 1'b0;
        // pat bit2 = sample0, bit1 = sample1, bit0 = sample2
        for (int p = 0; p < 6; p++) begin
            out_rdy = 1'b1; en = 1'b1;
            tick();
            for (int c = 1; c <= 12; c++) begin
                if (c <= 4)      in = pat[p][2];
                else if (c <= 8) in = pat[p][1];
                else             in = pat[p][0];
                tick();
            end
            checks++;
            if (out_val !== 1'b1) begin
                errors++; $display("FAIL vote%0d_val: got %b want 1", p, out_val);
            end
            checks++;
            if (out_bit !== exp_bit[p]) begin
                errors++;
                $display("FAIL vote%0d_bit: got %b want %b", p, out_bit, exp_bit[p]);
            end
`ifdef SAMPLE_VOTER_ERR_EN
            checks++;
            if (out_err !== exp_err[p]) begin
                errors++;
                $display("FAIL vote%0d_err: got %b want %b", p, out_err, exp_err[p]);
            end
`endif
            en = 1'b0;
            tick();
        end
    endtask

    // Ready low for two windows: first bit held, one overrun pulse at 24.
    task automatic test_overrun();
        logic eo;
        out_rdy = 1'b0; en = 1'b1; in = 1'b1;
        tick();
        for (int c = 1; c <= 25; c++) begin
            in = (c <= 12) ? 1'b1 : 1'b0;
            tick();
            eo = (c == 24);
            checks++;
            if (out_val !== (c >= 12)) begin
                errors++;
                $display("FAIL ovr_val c=%0d: got %b want %b", c, out_val, c >= 12);
            end
            if (c >= 12) begin
                checks++;
                if (out_bit !== 1'b1) begin
                    errors++;
                    $display("FAIL ovr_bit c=%0d: got %b want 1", c, out_bit);
                end
            end
            checks++;
            if (overrun !== eo) begin
                errors++;
                $display("FAIL ovr_pulse c=%0d: got %b want %b", c, overrun, eo);
            end
        end
        en = 1'b0; out_rdy = 1'b1;
        tick();
        checks++;
        if (out_val !== 1'b0) begin
            errors++; $display("FAIL ovr_drain: got %b want 0", out_val);
        end
    endtask

    // Ready raised exactly on the second vote edge.
    task automatic test_back_to_back();
        out_rdy = 1'b0; en = 1'b1; in = 1'b1;
        tick();
        for (int c = 1; c <= 24; c++) begin
            in = (c <= 12) ? 1'b1 : 1'b0;
            out_rdy = (c == 24);
            tick();
        end
        checks++;
        if (out_val !== 1'b1) begin
            errors++; $display("FAIL b2b_val: got %b want 1", out_val);
        end
        checks++;
        if (out_bit !== 1'b0) begin
            errors++; $display("FAIL b2b_bit: got %b want 0", out_bit);
        end
        checks++;
        if (overrun !== 1'b0) begin
            errors++; $display("FAIL b2b_ovr: got %b want 0", overrun);
        end
        en = 1'b0; out_rdy = 1'b1;
        tick();
        checks++;
        if (overrun !== 1'b0) begin
            errors++; $display("FAIL b2b_ovr2: got %b want 0", overrun);
        end
        checks++;
        if (out_val !== 1'b0) begin
            errors++; $display("FAIL b2b_drain: got %b want 0", out_val);
        end
    endtask

    // Abort after sample 1, then a fresh all-zero window.
    task automatic test_abort();
        out_rdy = 1'b1; en = 1'b1; in = 1'b1;
        tick();
        for (int c = 1; c <= 8; c++) tick();
        en = 1'b0;
        tick();
        tick();
        checks++;
        if (out_val !== 1'b0) begin
            errors++; $display("FAIL abort_val: got %b want 0", out_val);
        end
        in = 1'b0; en = 1'b1;
        tick();
        for (int c = 1; c <= 12; c++) begin
            tick();
            checks++;
            if (out_val !== (c == 12)) begin
                errors++;
                $display("FAIL abort_win c=%0d: got %b want %b", c, out_val, c == 12);
            end
        end
        checks++;
        if (out_bit !== 1'b0) begin
            errors++; $display("FAIL abort_bit: got %b want 0", out_bit);
        end
        en = 1'b0;
        tick();
    endtask

    // Async reset mid-window with a pending bit.
    task automatic test_async_reset();
        out_rdy = 1'b0; en = 1'b1; in = 1'b1;
        tick();
        for (int c = 1; c <= 14; c++) tick();
        checks++;
        if (out_val !== 1'b1) begin
            errors++; $display("FAIL ar_pre_val: got %b want 1", out_val);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_val !== 1'b0) begin
            errors++; $display("FAIL ar_val: got %b want 0", out_val);
        end
        checks++;
        if (out_bit !== 1'b0) begin
            errors++; $display("FAIL ar_bit: got %b want 0", out_bit);
        end
        checks++;
        if (overrun !== 1'b0) begin
            errors++; $display("FAIL ar_ovr: got %b want 0", overrun);
        end
`ifdef SAMPLE_VOTER_ERR_EN
        checks++;
        if (out_err !== 1'b0) begin
            errors++; $display("FAIL ar_err: got %b want 0", out_err);
        end
`endif
        en = 1'b0; out_rdy = 1'b1; in = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        en = 1'b1;
        tick();
        for (int c = 1; c <= 12; c++) begin
            tick();
            checks++;
            if (out_val !== (c == 12)) begin
                errors++;
                $display("FAIL ar_win c=%0d: got %b want %b", c, out_val, c == 12);
            end
        end
        checks++;
        if (out_bit !== 1'b0) begin
            errors++; $display("FAIL ar_newbit: got %b want 0", out_bit);
        end
        en = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_stream_ones();
        test_votes();
        test_overrun();
        test_back_to_back();
        test_abort();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
